nn_burst_block_memory: RTL and testbench

- Parametrised unified instruction/data/node memory for the NN processor. It replaces the single-cycle combinational memory with synchronous BRAM-style ports.
- Ports: one instruction read port, one data read/write port, and a node burst-read port. The burst port streams NODE_COUNT contiguous words as NODE_LANES-wide beats under a valid/ready handshake.
- Optional post-reset clear sweep zeroes the array one word per cycle.
- Sits between the CPU fetch/execute stages and the node-evaluation datapath.

---
 rtl/nn_mem_pkg.sv | 10 +
 rtl/nn_burst_block_memory_if.sv | 23 ++
 rtl/nn_node_burst_ctrl.sv | 93 +++++++++
 rtl/nn_burst_block_memory.sv | 109 ++++++++++
 tb/tb_nn_burst_block_memory.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_mem_pkg.sv
// Shared widths, word/address types and burst FSM states for the NN unified memory.
package nn_mem_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 11;

  typedef logic [DEF_DATA_W-1:0] word_t;
  typedef logic [DEF_ADDR_W-1:0] addr_t;

  typedef enum logic {IDLE, STREAM} burst_state_e;
endpackage

// File: rtl/nn_burst_block_memory_if.sv
// Link between the node burst controller (master) and the memory array (slave):
// request/stream handshake plus one combinational read lane per beat word.
interface nn_burst_block_memory_if #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 11,
  parameter int NODE_LANES = 4
);
  logic                                req;
  logic [ADDR_W-1:0]                   req_addr;
  logic                                req_rdy;
  logic                                busy;
  logic                                rdy;
  logic                                vld;
  logic                                last;
  logic [NODE_LANES-1:0][DATA_W-1:0]   nodes;
  logic [NODE_LANES-1:0][ADDR_W-1:0]   rd_addr;
  logic [NODE_LANES-1:0][DATA_W-1:0]   rd_dat;

  modport master (input req, req_addr, busy, rdy, rd_dat,
                  output req_rdy, vld, last, nodes, rd_addr);
  modport slave  (output req, req_addr, busy, rdy, rd_dat,
                  input req_rdy, vld, last, nodes, rd_addr);
endinterface

// File: rtl/nn_node_burst_ctrl.sv
// Node burst FSM: accepts a base address, streams BEATS registered beats, first beat 1 cycle after accept.
// Beats hold while the consumer stalls; the next beat is fetched on the handshake edge so there are no bubbles.
module nn_node_burst_ctrl
  import nn_mem_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int NODE_COUNT = 16,
  parameter int NODE_LANES = 4
) (
  input  logic iclk,
  input  logic irst_n,
  nn_burst_block_memory_if.master bus
);
  localparam int BEATS = NODE_COUNT / NODE_LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  burst_state_e                      r_state, w_state_nxt;
  logic [ADDR_W-1:0]                 r_base, w_base_nxt;
  logic [BW-1:0]                     r_beat, w_beat_nxt;
  logic                              r_vld, w_vld_nxt;
  logic                              r_last, w_last_nxt;
  logic [NODE_LANES-1:0][DATA_W-1:0] r_nodes, w_nodes_nxt;
  logic [ADDR_W-1:0]                 w_lane_base;
  logic                              w_req_rdy;

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      r_state <= IDLE;
      r_base  <= '0;
      r_beat  <= '0;
      r_vld   <= 1'b0;
      r_last  <= 1'b0;
      r_nodes <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_base  <= w_base_nxt;
      r_beat  <= w_beat_nxt;
      r_vld   <= w_vld_nxt;
      r_last  <= w_last_nxt;
      r_nodes <= w_nodes_nxt;
    end
  end

  // r_beat is the index of the next beat to fetch, not the one on the outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    w_beat_nxt  = r_beat;
    w_vld_nxt   = r_vld;
    w_last_nxt  = r_last;
    w_nodes_nxt = r_nodes;
    w_req_rdy   = 1'b0;
    w_lane_base = r_base + ADDR_W'(int'(r_beat) * NODE_LANES);
    case (r_state)
      IDLE: begin
        w_req_rdy   = !bus.busy;
        w_lane_base = bus.req_addr;
        if (bus.req && !bus.busy) begin
          w_state_nxt = STREAM;
          w_base_nxt  = bus.req_addr;
          w_beat_nxt  = BW'(1);
          w_vld_nxt   = 1'b1;
          w_last_nxt  = (BEATS == 1);
          w_nodes_nxt = bus.rd_dat;
        end
      end
      STREAM: begin
        if (r_vld && bus.rdy) begin
          if (r_last) begin
            w_state_nxt = IDLE;
            w_vld_nxt   = 1'b0;
            w_last_nxt  = 1'b0;
          end else begin
            w_nodes_nxt = bus.rd_dat;
            w_last_nxt  = (r_beat == BW'(BEATS - 1));
            w_beat_nxt  = r_beat + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  for (genvar k = 0; k < NODE_LANES; k++) begin : g_lane
    assign bus.rd_addr[k] = w_lane_base + ADDR_W'(k);
  end

  assign bus.req_rdy = w_req_rdy;
  assign bus.vld     = r_vld;
  assign bus.last    = r_last;
  assign bus.nodes   = r_nodes;
endmodule

// File: rtl/nn_burst_block_memory.sv
// Unified instr/data/node memory: registered instr and data reads (latency 1), optional post-reset clear sweep.
// Node bursts stream under valid/ready; requests and writes are refused while the sweep runs.
module nn_burst_block_memory
  import nn_mem_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int NODE_COUNT     = 16,
  parameter int NODE_LANES     = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                              iclk,
  input  logic                              irst_n,
  input  logic [15:0]                       iInstAddr,
  output logic [DATA_W-1:0]                 oInstr,
  input  logic [15:0]                       iDataAddr,
  input  logic                              iDataWe,
  input  logic [DATA_W-1:0]                 iData,
  output logic [DATA_W-1:0]                 oData,
  input  logic                              iNodeReq,
  input  logic [15:0]                       iNodeAddr,
  output logic                              oNodeReqReady,
  output logic [NODE_LANES-1:0][DATA_W-1:0] oNodes,
  output logic                              oNodeValid,
  output logic                              oNodeLast,
  input  logic                              iNodeReady,
  output logic                              oBusy
);
  localparam int DEPTH = 2 ** ADDR_W;

  if (NODE_COUNT % NODE_LANES != 0) begin : g_chk_lanes
    $error("NODE_COUNT must be a multiple of NODE_LANES");
  end
  if (ADDR_W < 1 || ADDR_W > 16) begin : g_chk_addr
    $error("ADDR_W must be in 1..16");
  end
  if (NODE_COUNT > DEPTH) begin : g_chk_depth
    $error("NODE_COUNT must not exceed DEPTH");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_busy;
  logic [DATA_W-1:0] r_instr, r_data;
  logic [ADDR_W-1:0] w_inst_addr, w_data_addr, w_waddr;
  logic [DATA_W-1:0] w_wdat;
  logic              w_we;
  logic              w_unused;

  assign w_inst_addr = iInstAddr[ADDR_W-1:0];
  assign w_data_addr = iDataAddr[ADDR_W-1:0];
  assign w_unused    = ^{iInstAddr, iDataAddr, iNodeAddr};

  // The sweep and the data port share the single write port; the sweep wins.
  assign w_we    = irst_n && (r_busy || iDataWe);
  assign w_waddr = r_busy ? r_clr_cnt : w_data_addr;
  assign w_wdat  = r_busy ? '0 : iData;

  always_ff @(posedge iclk) begin
    if (w_we) r_mem[w_waddr] <= w_wdat;
  end

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      r_clr_cnt <= '0;
      r_busy    <= (CLEAR_ON_RESET != 0);
      r_instr   <= '0;
      r_data    <= '0;
    end else if (r_busy) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
      r_instr   <= '0;
      r_data    <= '0;
      if (r_clr_cnt == ADDR_W'(DEPTH - 1)) r_busy <= 1'b0;
    end else begin
      r_instr <= r_mem[w_inst_addr];
      r_data  <= iDataWe ? iData : r_mem[w_data_addr];
    end
  end

  nn_burst_block_memory_if #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NODE_LANES(NODE_LANES)
  ) node_bus ();

  assign node_bus.req      = iNodeReq;
  assign node_bus.req_addr = iNodeAddr[ADDR_W-1:0];
  assign node_bus.rdy      = iNodeReady;
  assign node_bus.busy     = r_busy;

  always_comb begin
    node_bus.rd_dat = '0;
    for (int k = 0; k < NODE_LANES; k++) node_bus.rd_dat[k] = r_mem[node_bus.rd_addr[k]];
  end

  nn_node_burst_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NODE_COUNT(NODE_COUNT), .NODE_LANES(NODE_LANES)
  ) u_burst (
    .iclk  (iclk),
    .irst_n(irst_n),
    .bus   (node_bus.master)
  );

  assign oInstr        = r_instr;
  assign oData         = r_data;
  assign oBusy         = r_busy;
  assign oNodeReqReady = node_bus.req_rdy;
  assign oNodeValid    = node_bus.vld;
  assign oNodeLast     = node_bus.last;
  assign oNodes        = node_bus.nodes;
endmodule

// File: tb/tb_nn_burst_block_memory.sv
// Scoreboard bench for nn_burst_block_memory: clear sweep, data/instr ports, node bursts, stall, wrap, reset abort.
module tb_nn_burst_block_memory;
  import nn_mem_pkg::*;

  localparam int DEPTH = 2048;
  localparam int L     = 4;
  localparam int BEATS = 4;

  typedef struct {
    logic [L-1:0][15:0] nodes;
    logic               last;
  } exp_t;

  typedef struct {
    logic [L-1:0][15:0] nodes;
    logic               last;
    bit                 hs;
    int                 t;
  } obs_t;

  logic        iclk = 1'b0;
  logic        irst_n;
  logic [15:0] iInstAddr, iDataAddr, iData, iNodeAddr;
  logic        iDataWe;
  logic [15:0] oInstr, oData;

  int    checks   = 0;
  int    failures = 0;
  word_t model [DEPTH];
  exp_t  exp_q [$];
  obs_t  obs_q [$];

  nn_burst_block_memory_if #(.DATA_W(16), .ADDR_W(11), .NODE_LANES(L)) tb_bus ();

  assign tb_bus.req_addr = iNodeAddr[10:0];
  assign tb_bus.rd_addr  = '0;
  assign tb_bus.rd_dat   = '0;

  nn_burst_block_memory #(
    .DATA_W(16), .ADDR_W(11), .NODE_COUNT(16), .NODE_LANES(L), .CLEAR_ON_RESET(1)
  ) dut (
    .iclk         (iclk),
    .irst_n       (irst_n),
    .iInstAddr    (iInstAddr),
    .oInstr       (oInstr),
    .iDataAddr    (iDataAddr),
    .iDataWe      (iDataWe),
    .iData        (iData),
    .oData        (oData),
    .iNodeReq     (tb_bus.req),
    .iNodeAddr    (iNodeAddr),
    .oNodeReqReady(tb_bus.req_rdy),
    .oNodes       (tb_bus.nodes),
    .oNodeValid   (tb_bus.vld),
    .oNodeLast    (tb_bus.last),
    .iNodeReady   (tb_bus.rdy),
    .oBusy        (tb_bus.busy)
  );

  always #5 iclk = ~iclk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc();
    @(posedge iclk);
    #1;
  endtask

  task automatic write_word(input int a, input logic [15:0] d);
    iDataAddr = 16'(a);
    iData     = d;
    iDataWe   = 1'b1;
    wait_cyc();
    iDataWe   = 1'b0;
    model[a % DEPTH] = d;
  endtask

  // Drives one burst and records every valid beat seen; scoring is done by the caller.
  task automatic burst_stream(input int base, input int stall_beat, input int stall_n, output bit ok);
    int   n, beat, stalled;
    exp_t e;
    obs_t o;
    ok = 1'b0;
    iNodeAddr  = 16'(base);
    tb_bus.req = 1'b1;
    tb_bus.rdy = 1'b1;
    n = 0;
    while (!tb_bus.req_rdy && n < 100) begin
      wait_cyc();
      n++;
    end
    if (!tb_bus.req_rdy) begin
      tb_bus.req = 1'b0;
      return;
    end
    for (int b = 0; b < BEATS; b++) begin
      for (int k = 0; k < L; k++) e.nodes[k] = model[(base + b * L + k) % DEPTH];
      e.last = (b == BEATS - 1);
      exp_q.push_back(e);
    end
    wait_cyc();
    tb_bus.req = 1'b0;
    beat = 0;
    stalled = 0;
    for (int t = 0; t < 64; t++) begin
      if (tb_bus.vld) begin
        o.nodes = tb_bus.nodes;
        o.last  = tb_bus.last;
        o.t     = t;
        o.hs    = !(beat == stall_beat && stalled < stall_n);
        if (!o.hs) stalled++;
        tb_bus.rdy = o.hs;
        obs_q.push_back(o);
        if (o.hs) beat++;
        if (o.hs && o.last) begin
          wait_cyc();
          tb_bus.rdy = 1'b1;
          ok = 1'b1;
          return;
        end
      end
      wait_cyc();
    end
    tb_bus.rdy = 1'b1;
  endtask

  task automatic test_reset();
    int n, rdy_bad;
    irst_n = 1'b0;
    repeat (2) wait_cyc();
    checks++; if (tb_bus.vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b want=0", tb_bus.vld); end
    checks++; if (tb_bus.last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b want=0", tb_bus.last); end
    checks++; if (oInstr !== 16'h0 || oData !== 16'h0) begin failures++; $display("FAIL reset_rd instr=%h data=%h want=0000", oInstr, oData); end
    checks++; if (tb_bus.busy !== 1'b1 || tb_bus.req_rdy !== 1'b0) begin failures++; $display("FAIL reset_busy busy=%b rdy=%b want busy=1 rdy=0", tb_bus.busy, tb_bus.req_rdy); end
    irst_n = 1'b1;
    n = 0;
    rdy_bad = 0;
    while (tb_bus.busy === 1'b1 && n < 3000) begin
      if (tb_bus.req_rdy !== 1'b0) rdy_bad++;
      n++;
      wait_cyc();
    end
    checks++; if (n != DEPTH) begin failures++; $display("FAIL clear_len got=%0d want=%0d", n, DEPTH); end
    checks++; if (rdy_bad != 0) begin failures++; $display("FAIL busy_req_rdy got=%0d cycles with ready want=0", rdy_bad); end
    checks++; if (tb_bus.req_rdy !== 1'b1) begin failures++; $display("FAIL post_clear_rdy got=%b want=1", tb_bus.req_rdy); end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic test_clear_read();
    iInstAddr = 16'h005;
    wait_cyc();
    checks++; if (oInstr !== 16'h0000) begin failures++; $display("FAIL clear_read got=%h want=0000", oInstr); end
  endtask

  task automatic test_write_first();
    iInstAddr = 16'h010;
    iDataAddr = 16'h010;
    iData     = 16'h1234;
    iDataWe   = 1'b1;
    wait_cyc();
    iDataWe   = 1'b0;
    model[16'h010] = 16'h1234;
    checks++; if (oInstr !== 16'h0000) begin failures++; $display("FAIL instr_read_first got=%h want=0000", oInstr); end
    checks++; if (oData !== 16'h1234) begin failures++; $display("FAIL data_write_first got=%h want=1234", oData); end
    wait_cyc();
    checks++; if (oInstr !== 16'h1234) begin failures++; $display("FAIL instr_after_write got=%h want=1234", oInstr); end
    write_word(16'h0810, 16'h5678);
    iDataAddr = 16'h0010;
    iInstAddr = 16'h0810;
    wait_cyc();
    checks++; if (oData !== 16'h5678) begin failures++; $display("FAIL alias_data got=%h want=5678", oData); end
    checks++; if (oInstr !== 16'h5678) begin failures++; $display("FAIL alias_instr got=%h want=5678", oInstr); end
  endtask

  task automatic test_burst_basic();
    bit   ok;
    int   n_hs;
    exp_t e;
    obs_t o;
    for (int i = 0; i < 16; i++) write_word(i, 16'(16'h100 + i));
    burst_stream(0, -1, 0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_done got=timeout want=last handshake"); end
    n_hs = 0;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL basic_extra beat t=%0d nodes=%h want=none", o.t, o.nodes); end
      else begin
        e = exp_q.pop_front();
        if (o.nodes !== e.nodes || o.last !== e.last || o.t != n_hs)
          begin failures++; $display("FAIL basic_beat%0d got t=%0d nodes=%h last=%b want t=%0d nodes=%h last=%b", n_hs, o.t, o.nodes, o.last, n_hs, e.nodes, e.last); end
      end
      n_hs++;
    end
    checks++; if (n_hs != BEATS || exp_q.size() != 0) begin failures++; $display("FAIL basic_count got=%0d want=%0d", n_hs, BEATS); end
    exp_q.delete();
    checks++; if (tb_bus.vld !== 1'b0 || tb_bus.req_rdy !== 1'b1) begin failures++; $display("FAIL basic_idle vld=%b rdy=%b want vld=0 rdy=1", tb_bus.vld, tb_bus.req_rdy); end
  endtask

  task automatic test_stall();
    bit   ok;
    int   n_hs, n_stall;
    exp_t e;
    obs_t o;
    burst_stream(0, 1, 3, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_done got=timeout want=last handshake"); end
    n_hs = 0;
    n_stall = 0;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL stall_extra beat t=%0d nodes=%h want=none", o.t, o.nodes); end
      else begin
        e = o.hs ? exp_q.pop_front() : exp_q[0];
        if (o.nodes !== e.nodes || o.last !== e.last)
          begin failures++; $display("FAIL stall_beat t=%0d got nodes=%h last=%b want nodes=%h last=%b", o.t, o.nodes, o.last, e.nodes, e.last); end
      end
      if (o.hs) n_hs++; else n_stall++;
    end
    checks++; if (n_hs != BEATS || n_stall != 3 || exp_q.size() != 0) begin failures++; $display("FAIL stall_count got hs=%0d stall=%0d want hs=%0d stall=3", n_hs, n_stall, BEATS); end
    exp_q.delete();
  endtask

  task automatic test_wrap();
    bit    ok;
    int    n_hs;
    exp_t  e;
    obs_t  o;
    addr_t base;
    base = 11'h7FC;
    for (int i = 0; i < 4; i++) write_word(16'h7FC + i, 16'(16'hA0 + i));
    for (int i = 0; i < 4; i++) write_word(i, 16'(16'hB0 + i));
    burst_stream(int'(base), -1, 0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_done got=timeout want=last handshake"); end
    n_hs = 0;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL wrap_extra beat nodes=%h want=none", o.nodes); end
      else begin
        e = exp_q.pop_front();
        if (o.nodes !== e.nodes || o.last !== e.last)
          begin failures++; $display("FAIL wrap_beat%0d got nodes=%h last=%b want nodes=%h last=%b", n_hs, o.nodes, o.last, e.nodes, e.last); end
      end
      n_hs++;
    end
    checks++; if (n_hs != BEATS) begin failures++; $display("FAIL wrap_count got=%0d want=%0d", n_hs, BEATS); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_burst();
    int n, seen;
    iNodeAddr  = 16'h0;
    tb_bus.req = 1'b1;
    tb_bus.rdy = 1'b1;
    n = 0;
    while (!tb_bus.req_rdy && n < 100) begin wait_cyc(); n++; end
    wait_cyc();
    tb_bus.req = 1'b0;
    repeat (2) wait_cyc();
    checks++; if (tb_bus.vld !== 1'b1 || tb_bus.last !== 1'b0) begin failures++; $display("FAIL mid_beat2 vld=%b last=%b want vld=1 last=0", tb_bus.vld, tb_bus.last); end
    irst_n = 1'b0;
    wait_cyc();
    irst_n = 1'b1;
    checks++; if (tb_bus.vld !== 1'b0 || tb_bus.last !== 1'b0) begin failures++; $display("FAIL abort_vld vld=%b last=%b want 0 0", tb_bus.vld, tb_bus.last); end
    checks++; if (tb_bus.busy !== 1'b1 || tb_bus.req_rdy !== 1'b0) begin failures++; $display("FAIL abort_busy busy=%b rdy=%b want busy=1 rdy=0", tb_bus.busy, tb_bus.req_rdy); end
    tb_bus.req = 1'b1;
    n = 0;
    seen = 0;
    while (tb_bus.busy === 1'b1 && n < 3000) begin
      if (tb_bus.vld !== 1'b0 || tb_bus.req_rdy !== 1'b0) seen++;
      n++;
      wait_cyc();
    end
    tb_bus.req = 1'b0;
    checks++; if (seen != 0) begin failures++; $display("FAIL req_ignored got=%0d active cycles want=0", seen); end
    checks++; if (n != DEPTH) begin failures++; $display("FAIL reclear_len got=%0d want=%0d", n, DEPTH); end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    iInstAddr = 16'h7FC;
    wait_cyc();
    checks++; if (tb_bus.vld !== 1'b0) begin failures++; $display("FAIL post_abort_vld got=%b want=0", tb_bus.vld); end
    checks++; if (oInstr !== model[16'h7FC]) begin failures++; $display("FAIL reclear_read got=%h want=%h", oInstr, model[16'h7FC]); end
  endtask

  initial begin
    irst_n     = 1'b0;
    iInstAddr  = '0;
    iDataAddr  = '0;
    iData      = '0;
    iDataWe    = 1'b0;
    iNodeAddr  = '0;
    tb_bus.req = 1'b0;
    tb_bus.rdy = 1'b1;
    test_reset();
    test_clear_read();
    test_write_first();
    test_burst_basic();
    test_stall();
    test_wrap();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
